// File: rtl/zion_basic_circuit_lib_pkg.sv
// zion_basic_circuit_lib_pkg: sizing helpers shared by the pipeline register and its instantiation macro.
`ifndef ZION_PIPE_REG_MACRO
`define ZION_PIPE_REG_MACRO
`define ZION_PIPE_REG(inst, depth, reg_ready, clk_i, rst_n_i, flush_i, ivld, irdy, idat, ovld, ordy, odat, ocnt) \
  zion_basic_circuit_lib_pipe_reg #( \
    .WIDTH_IN($bits(idat)), .WIDTH_OUT($bits(odat)), .DEPTH(depth), .REG_READY(reg_ready) \
  ) inst ( \
    .clk(clk_i), .rst_n(rst_n_i), .iFlush(flush_i), .iVld(ivld), .iRdy(irdy), .iDat(idat), \
    .oVld(ovld), .oRdy(ordy), .oDat(odat), .oCnt(ocnt));
`endif

package zion_basic_circuit_lib_pkg;
  function automatic int pipe_cap(input int depth, input int reg_ready);
    return depth * ((reg_ready != 0) ? 2 : 1);
  endfunction
  function automatic int cnt_w(input int cap);
    return (cap < 1) ? 1 : $clog2(cap + 1);
  endfunction
endpackage

// File: rtl/zion_basic_circuit_lib_pipe_stage.sv
// zion_basic_circuit_lib_pipe_stage: one elastic stage, either a single entry with
// combinational ready or a main+skid pair whose ready comes straight from a flop.
module zion_basic_circuit_lib_pipe_stage #(
    parameter int WIDTH = 8,
    parameter int REG_READY = 0,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);
    logic             main_vld;
    logic [WIDTH-1:0] main_dat;

    assign out_vld = main_vld;
    assign out_dat = main_dat;

    if (REG_READY == 0) begin : g_simple
        assign in_rdy = !main_vld || out_rdy;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_vld <= 1'b0;
                main_dat <= INI_DATA;
            end else if (flush) begin
                main_vld <= 1'b0;
                main_dat <= INI_DATA;
            end else if (in_rdy) begin
                main_vld <= in_vld;
                if (in_vld) main_dat <= in_dat;
            end
        end
    end else begin : g_skid
        logic             skid_vld;
        logic [WIDTH-1:0] skid_dat;
        assign in_rdy = !skid_vld;
        // The skid only fills while main is stalled, so it always holds the younger beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_vld <= 1'b0;
                main_dat <= INI_DATA;
                skid_vld <= 1'b0;
                skid_dat <= INI_DATA;
            end else if (flush) begin
                main_vld <= 1'b0;
                main_dat <= INI_DATA;
                skid_vld <= 1'b0;
                skid_dat <= INI_DATA;
            end else if (!main_vld || out_rdy) begin
                if (skid_vld) begin
                    main_vld <= 1'b1;
                    main_dat <= skid_dat;
                    skid_vld <= 1'b0;
                end else begin
                    main_vld <= in_vld;
                    if (in_vld) main_dat <= in_dat;
                end
            end else if (in_vld && !skid_vld) begin
                skid_vld <= 1'b1;
                skid_dat <= in_dat;
            end
        end
    end

endmodule

// File: rtl/zion_basic_circuit_lib_pipe_reg.sv
// zion_basic_circuit_lib_pipe_reg: DEPTH-stage valid/ready pipeline register with
// bubble collapsing, optional registered ready, synchronous flush and occupancy count.
module zion_basic_circuit_lib_pipe_reg
    import zion_basic_circuit_lib_pkg::*;
#(
    parameter int WIDTH_IN = 8,
    parameter int WIDTH_OUT = 8,
    parameter int DEPTH = 2,
    parameter int REG_READY = 0,
    parameter logic [WIDTH_IN-1:0] INI_DATA = '0
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          iFlush,
    input  logic                                          iVld,
    output logic                                          iRdy,
    input  logic [WIDTH_IN-1:0]                           iDat,
    output logic                                          oVld,
    input  logic                                          oRdy,
    output logic [WIDTH_OUT-1:0]                          oDat,
    output logic [cnt_w(pipe_cap(DEPTH, REG_READY))-1:0]  oCnt
);
    localparam int CW = cnt_w(pipe_cap(DEPTH, REG_READY));

    if (WIDTH_IN != WIDTH_OUT || DEPTH > 16) begin : g_bad_param
        $error("zion_basic_circuit_lib_pipe_reg: WIDTH_IN must equal WIDTH_OUT and DEPTH must be 0..16");
    end

    if (DEPTH == 0) begin : g_pass
        assign iRdy = oRdy;
        assign oVld = iVld;
        assign oDat = WIDTH_OUT'(iDat);
        assign oCnt = '0;
    end else begin : g_pipe
        logic [DEPTH:0]               vld;
        logic [DEPTH:0]               rdy;
        logic [DEPTH:0][WIDTH_IN-1:0] dat;
        logic                         up;
        logic                         dn;

        assign vld[0]     = iVld;
        assign dat[0]     = iDat;
        assign rdy[DEPTH] = oRdy;
        // Nothing is accepted while held in reset or during the flush cycle.
        assign iRdy = rst_n && !iFlush && rdy[0];
        assign oVld = vld[DEPTH];
        assign oDat = WIDTH_OUT'(dat[DEPTH]);
        assign up   = iVld && iRdy;
        assign dn   = oVld && oRdy;

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            zion_basic_circuit_lib_pipe_stage #(
                .WIDTH(WIDTH_IN),
                .REG_READY(REG_READY),
                .INI_DATA(INI_DATA)
            ) u_stage (
                .clk(clk),
                .rst_n(rst_n),
                .flush(iFlush),
                .in_vld(vld[k]),
                .in_rdy(rdy[k]),
                .in_dat(dat[k]),
                .out_vld(vld[k+1]),
                .out_rdy(rdy[k+1]),
                .out_dat(dat[k+1])
            );
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) oCnt <= '0;
            else if (iFlush) oCnt <= '0;
            else oCnt <= oCnt + CW'(up) - CW'(dn);
        end
    end

endmodule

// File: tb/tb_zion_basic_circuit_lib_pipe_reg.sv
// tb_zion_basic_circuit_lib_pipe_reg: three pipes (depth 3 plain, depth 3 skid, depth 0)
// checked every cycle against a queue model of in-flight beats plus literal expectations.
module tb_zion_basic_circuit_lib_pipe_reg;
    localparam int DEP[3] = '{3, 3, 0};
    localparam int CAP[3] = '{3, 6, 0};
    localparam int RR[3]  = '{0, 1, 0};
    localparam logic [7:0] INI[3] = '{8'h5A, 8'hC3, 8'h00};

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [2:0]      ivld, irdy, ovld, ordy;
    logic [2:0][7:0] idat, odat;
    logic [1:0]      ocnt_a;
    logic [2:0]      ocnt_b;
    logic [0:0]      ocnt_c;
    int              cnt[3];

    int checks = 0;
    int errors = 0;
    int n = 0;
    logic [7:0] qd[3][$];
    int         qc[3][$];
    bit   acc_in[3];
    int   in_n[3], out_n[3], last_lat[3];
    logic [7:0] last_out[3];
    logic [7:0] nxt[3];
    logic [7:0] inc;
    int   sz;
    bit   ev, ia, oa;

    always #5 clk = ~clk;

    zion_basic_circuit_lib_pipe_reg #(.WIDTH_IN(8), .WIDTH_OUT(8), .DEPTH(3), .REG_READY(0), .INI_DATA(8'h5A)) u_a (
        .clk(clk), .rst_n(rst_n), .iFlush(flush), .iVld(ivld[0]), .iRdy(irdy[0]), .iDat(idat[0]),
        .oVld(ovld[0]), .oRdy(ordy[0]), .oDat(odat[0]), .oCnt(ocnt_a));
    zion_basic_circuit_lib_pipe_reg #(.WIDTH_IN(8), .WIDTH_OUT(8), .DEPTH(3), .REG_READY(1), .INI_DATA(8'hC3)) u_b (
        .clk(clk), .rst_n(rst_n), .iFlush(flush), .iVld(ivld[1]), .iRdy(irdy[1]), .iDat(idat[1]),
        .oVld(ovld[1]), .oRdy(ordy[1]), .oDat(odat[1]), .oCnt(ocnt_b));
    zion_basic_circuit_lib_pipe_reg #(.WIDTH_IN(8), .WIDTH_OUT(8), .DEPTH(0), .REG_READY(0)) u_c (
        .clk(clk), .rst_n(rst_n), .iFlush(flush), .iVld(ivld[2]), .iRdy(irdy[2]), .iDat(idat[2]),
        .oVld(ovld[2]), .oRdy(ordy[2]), .oDat(odat[2]), .oCnt(ocnt_c));

    always_comb begin
        cnt[0] = int'(ocnt_a);
        cnt[1] = int'(ocnt_b);
        cnt[2] = int'(ocnt_c);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, act, exp, n);
        end
    endtask

    // Model: a beat accepted in cycle c is presented at the output from cycle c+DEPTH
    // onward once every older beat has left; count equals beats in flight.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (DEP[d] == 0) begin
                chk($sformatf("pass_vld%0d", d), int'(ovld[d]), int'(ivld[d]));
                chk($sformatf("pass_dat%0d", d), int'(odat[d]), int'(idat[d]));
                chk($sformatf("pass_rdy%0d", d), int'(irdy[d]), int'(ordy[d]));
                chk($sformatf("pass_cnt%0d", d), cnt[d], 0);
                acc_in[d] = ivld[d] && irdy[d];
            end else if (!rst_n) begin
                chk($sformatf("rst_vld%0d", d), int'(ovld[d]), 0);
                chk($sformatf("rst_cnt%0d", d), cnt[d], 0);
                chk($sformatf("rst_rdy%0d", d), int'(irdy[d]), 0);
                chk($sformatf("rst_dat%0d", d), int'(odat[d]), int'(INI[d]));
                qd[d].delete();
                qc[d].delete();
                acc_in[d] = 1'b0;
            end else begin
                sz = qd[d].size();
                ev = sz > 0 && qc[d][0] + DEP[d] <= n;
                chk($sformatf("ovld%0d", d), int'(ovld[d]), int'(ev));
                if (ev) chk($sformatf("odat%0d", d), int'(odat[d]), int'(qd[d][0]));
                chk($sformatf("ocnt%0d", d), cnt[d], sz);
                if (flush) chk($sformatf("flush_rdy%0d", d), int'(irdy[d]), 0);
                else if (RR[d] == 0) chk($sformatf("irdy%0d", d), int'(irdy[d]), int'(sz < CAP[d] || ordy[d]));
                else if (sz == CAP[d]) chk($sformatf("full_rdy%0d", d), int'(irdy[d]), 0);
                else if (sz == 0) chk($sformatf("empty_rdy%0d", d), int'(irdy[d]), 1);
                ia = ivld[d] && irdy[d];
                oa = ev && ordy[d];
                if (oa) begin
                    last_lat[d] = n - qc[d][0];
                    last_out[d] = qd[d][0];
                    out_n[d]++;
                    void'(qd[d].pop_front());
                    void'(qc[d].pop_front());
                end
                if (flush) begin
                    qd[d].delete();
                    qc[d].delete();
                end else if (ia) begin
                    qd[d].push_back(idat[d]);
                    qc[d].push_back(n);
                    in_n[d]++;
                end
                acc_in[d] = ia;
            end
        end
        n++;
    end

    // vm/om: 0 = low, 1 = high, 2 = random; an unaccepted beat is always held.
    task automatic step(input int vm, input int om, input bit fl);
        @(posedge clk);
        #1;
        flush = fl;
        for (int d = 0; d < 3; d++) begin
            ordy[d] = (om == 2) ? 1'($urandom_range(0, 1)) : (om == 1);
            if (!ivld[d] || acc_in[d]) begin
                ivld[d] = (vm == 2) ? ($urandom_range(0, 3) != 0) : (vm == 1);
                if (ivld[d]) begin
                    idat[d] = (vm == 2) ? 8'($urandom) : nxt[d];
                    nxt[d] = nxt[d] + inc;
                end
            end
        end
    endtask

    task automatic peek;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int base;
        bit rel;
        rst_n = 1'b0;
        flush = 1'b0;
        ivld = 3'b111;
        idat = {3{8'hAA}};
        ordy = '0;
        inc = 8'h01;
        nxt = '{8'h01, 8'h01, 8'h01};
        repeat (3) peek();
        chk("reset_ovld_a", int'(ovld[0]), 0);
        chk("reset_ocnt_a", cnt[0], 0);
        chk("reset_odat_a", int'(odat[0]), 'h5A);
        chk("reset_odat_b", int'(odat[1]), 'hC3);
        chk("reset_irdy_b", int'(irdy[1]), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ivld = '0;
        peek();
        chk("release_irdy_a", int'(irdy[0]), 1);
        chk("release_irdy_b", int'(irdy[1]), 1);

        base = out_n[0];
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 0);
            if (i == 8) begin
                peek();
                chk("stream_cnt_a", cnt[0], 3);
                chk("stream_cnt_b", cnt[1], 3);
            end
        end
        repeat (6) step(0, 1, 0);
        peek();
        chk("stream_beats_a", out_n[0] - base, 16);
        chk("stream_lat_a", last_lat[0], 3);
        chk("stream_lat_b", last_lat[1], 3);
        chk("stream_last_a", int'(last_out[0]), 'h10);

        repeat (10) step(1, 0, 0);
        peek();
        chk("bp_cnt_a", cnt[0], 3);
        chk("bp_irdy_a", int'(irdy[0]), 0);
        chk("bp_cnt_b", cnt[1], 6);
        chk("bp_irdy_b", int'(irdy[1]), 0);
        repeat (12) step(0, 1, 0);
        peek();
        chk("bp_drained_a", cnt[0], 0);
        chk("bp_drained_b", cnt[1], 0);
        chk("bp_inout_a", out_n[0], in_n[0]);
        chk("bp_inout_b", out_n[1], in_n[1]);

        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        repeat (4) step(0, 0, 0);
        peek();
        chk("bubble_cnt_a", cnt[0], 2);
        chk("bubble_ovld_a", int'(ovld[0]), 1);
        step(0, 1, 0);
        peek();
        chk("bubble_first_a", int'(ovld[0]), 1);
        step(0, 1, 0);
        peek();
        chk("bubble_second_a", int'(ovld[0]), 1);
        step(0, 1, 0);
        peek();
        chk("bubble_done_a", int'(ovld[0]), 0);
        repeat (6) step(0, 1, 0);

        nxt = '{8'h11, 8'h11, 8'h11};
        inc = 8'h11;
        repeat (3) step(1, 0, 0);
        step(1, 0, 1);
        peek();
        chk("flush_irdy_a", int'(irdy[0]), 0);
        chk("flush_held_a", int'(idat[0]), 'h44);
        step(1, 0, 0);
        peek();
        chk("post_flush_ovld_a", int'(ovld[0]), 0);
        chk("post_flush_cnt_a", cnt[0], 0);
        chk("post_flush_irdy_a", int'(irdy[0]), 1);
        repeat (6) step(0, 1, 0);
        peek();
        chk("post_flush_out_a", int'(last_out[0]), 'h44);
        chk("post_flush_out_b", int'(last_out[1]), 'h44);

        inc = 8'h01;
        rel = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step(2, 2, $urandom_range(0, 19) == 0);
            if (rel) begin
                rst_n = 1'b1;
                rel = 1'b0;
            end
            if (i == 150) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("async_rst_ovld_a", int'(ovld[0]), 0);
                chk("async_rst_cnt_a", cnt[0], 0);
                chk("async_rst_ovld_b", int'(ovld[1]), 0);
                chk("async_rst_cnt_b", cnt[1], 0);
                rel = 1'b1;
            end
        end
        repeat (10) step(0, 1, 0);
        peek();
        chk("final_cnt_a", cnt[0], 0);
        chk("final_cnt_b", cnt[1], 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
